// File: rtl/regfile_writeback_queue_pkg.sv
// ============================================================================
// mips_pkg : shared widths and writeback entry type for regfile_writeback_queue
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_writeback_queue_if.sv
// ============================================================================
// regfile_writeback_queue_if : result push handshake and register file write port
// Revision : 1.0
// ============================================================================
`default_nettype none

interface regfile_writeback_queue_if;

   logic                            in_valid;
   logic                            in_ready;
   logic [mips_pkg::REG_ADDR_W-1:0] in_reg;
   logic [mips_pkg::DATA_W-1:0]     in_data;
   logic                            wb_hold;
   logic                            RegWrite;
   logic [mips_pkg::REG_ADDR_W-1:0] writeRegister;
   logic [mips_pkg::DATA_W-1:0]     writeDataregs;

   modport master (
      output in_valid, in_reg, in_data, wb_hold,
      input  in_ready, RegWrite, writeRegister, writeDataregs
   );

   modport slave (
      input  in_valid, in_reg, in_data, wb_hold,
      output in_ready, RegWrite, writeRegister, writeDataregs
   );

endinterface

`default_nettype wire

// File: rtl/regfile_writeback_queue_match.sv
// ============================================================================
// wb_match_unit : in-flight hazard lookup over the writeback queue entries
// Forwarded data is built only when REGFILE_WB_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_match_unit
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AGE_W = 2
) (
   input  wb_entry_t             entries [DEPTH],
   input  logic [DEPTH-1:0]      valid,
   input  logic [AGE_W-1:0]      age [DEPTH],
   input  logic [REG_ADDR_W-1:0] query_reg,
   output logic                  query_pending,
   output logic [DATA_W-1:0]     query_data
);

   logic [DEPTH-1:0] hit;

   for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign hit[i] = valid[i] && (entries[i].dest == query_reg);
   end

   assign query_pending = (|hit) && (query_reg != REG_ZERO);

`ifdef REGFILE_WB_BYPASS_EN
   logic             found;
   logic [AGE_W-1:0] best_age;

   // Larger age means pushed later, so the youngest hit wins.
   always_comb begin
      found      = 1'b0;
      best_age   = '0;
      query_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (hit[i] && (!found || (age[i] > best_age))) begin
            found      = 1'b1;
            best_age   = age[i];
            query_data = entries[i].data;
         end
      end
      if (query_reg == REG_ZERO) begin
         query_data = '0;
      end
   end
`else
   logic [DEPTH-1:0] unused_fields;

   for (genvar i = 0; i < DEPTH; i++) begin : g_unused
      assign unused_fields[i] = ^{entries[i].data, age[i]};
   end

   assign query_data = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_writeback_queue.sv
// ============================================================================
// regfile_writeback_queue : in-order result queue draining onto the MIPS register file write port
// Optional forwarding of query_data enabled by REGFILE_WB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_writeback_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   regfile_writeback_queue_if.slave      bus,
   input  logic [REG_ADDR_W-1:0]         query_reg,
   output logic                          query_pending,
   output logic [DATA_W-1:0]             query_data,
   output logic [$clog2(DEPTH+1)-1:0]    count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_entry_t             mem_q [DEPTH];
   wb_entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  reg_write_q, reg_write_d;
   logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0]     write_data_q, write_data_d;

   logic                  pop, push_fire, push_store;
   logic [PTR_W-1:0]      head_next;
   logic [CNT_W-1:0]      remaining;
   logic [PTR_W-1:0]      slot_age [DEPTH];
   logic [DEPTH-1:0]      slot_valid;

   assign bus.in_ready      = (count_q != CNT_W'(DEPTH));
   assign bus.RegWrite      = reg_write_q;
   assign bus.writeRegister = write_reg_q;
   assign bus.writeDataregs = write_data_q;
   assign count             = count_q;

   // The entry on the write port stays in the queue until the edge that commits it.
   always_comb begin
      mem_d        = mem_q;
      tail_d       = tail_q;
      pop          = reg_write_q;
      push_fire    = bus.in_valid && bus.in_ready;
      push_store   = push_fire && (bus.in_reg != REG_ZERO);
      head_next    = head_q + PTR_W'(pop);
      remaining    = count_q - CNT_W'(pop);
      head_d       = head_next;
      count_d      = remaining + CNT_W'(push_store);
      if (push_store) begin
         mem_d[tail_q] = '{dest: bus.in_reg, data: bus.in_data};
         tail_d        = tail_q + PTR_W'(1);
      end
      reg_write_d  = (remaining != '0) && !bus.wb_hold;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (reg_write_d) begin
         write_reg_d  = mem_q[head_next].dest;
         write_data_d = mem_q[head_next].data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         mem_q        <= mem_d;
      end
   end

   // Age is the distance from the head; an entry is live when that distance is below the count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      assign slot_age[i]   = PTR_W'(i) - head_q;
      assign slot_valid[i] = (CNT_W'(slot_age[i]) < count_q);
   end

   wb_match_unit #(
      .DEPTH (DEPTH),
      .AGE_W (PTR_W)
   ) u_match (
      .entries       (mem_q),
      .valid         (slot_valid),
      .age           (slot_age),
      .query_reg     (query_reg),
      .query_pending (query_pending),
      .query_data    (query_data)
   );

endmodule

`default_nettype wire

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Writer-side front end for the 32 x 32-bit MIPS register file: it accepts destination/data results from the execute and memory stages over a valid/ready handshake, buffers them in a small in-order queue, and drains one entry per cycle onto the register file write port (`RegWrite`, `writeRegister`, `writeDataregs`). It also reports whether a queried register has a write still in flight, so decode can stall on read-after-write hazards.

## Interface
- `DEPTH`, 4, queue entries; power of two, minimum 2
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  result offered
- `in_ready`  out  1  queue can accept; equals `!full`
- `in_reg`  in  5  destination register number
- `in_data`  in  32  result value
- `wb_hold`  in  1  when high, no entry drains this cycle
- `RegWrite`  out  1  register file write enable
- `writeRegister`  out  5  register file write address
- `writeDataregs`  out  32  register file write data
- `query_reg`  in  5  register being read by decode
- `query_pending`  out  1  a queued or draining entry targets `query_reg`
- `query_data`  out  32  forwarded value; see Configuration
- `count`  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular buffer with head pointer, tail pointer and occupancy counter; pointers are $clog2(DEPTH) bits and wrap naturally.
- Push: `in_valid && in_ready` at a rising edge. `in_reg`/`in_data` are written at the tail; the tail advances.
- Register 0: a push with `in_reg == 0` completes the handshake but is discarded. Nothing is stored and the count is unchanged.
- Drain: when the queue is non-empty and `wb_hold` is low, `RegWrite` is 1 and `writeRegister`/`writeDataregs` equal the head entry. The head pops at that edge.
- When the queue is empty or `wb_hold` is high:
  - `RegWrite` = 0.
  - `writeRegister` and `writeDataregs` hold their last values.
- Simultaneous push and pop: count unchanged, both pointers advance.
- `in_ready` is based only on the registered count, with no dependence on pop in the same cycle. When full, a push is refused even if a pop occurs in that cycle.
- Ordering is strictly FIFO. Multiple entries to the same register drain oldest first, so the last write wins.
- `query_pending` = OR over valid entries of (`dest == query_reg`). It is forced to 0 when `query_reg == 0`. This is purely combinational from state, with no path from `in_*`.

## Timing
- Reset values:
  - Pointers and count are 0.
  - `in_ready` is 1 (combinational from the reset count).
  - `RegWrite` is 0.
  - `writeRegister` is 0.
  - `writeDataregs` is 0.
  - `query_pending` is 0.
  - `query_data` is 0.
- Output path:
  - `RegWrite`, `writeRegister` and `writeDataregs` are registered, loaded at the edge that selects the head entry. `RegWrite` high in cycle N+1 means the head entry is committed by the register file at the edge ending N+1.
  - Latency with the queue empty: push accepted at edge N, so `RegWrite` is high during cycle N+1. The entry is counted in `query_pending` from edge N onward, including its `RegWrite` cycle, until it is removed at edge N+2.
- Throughput is one write per cycle while non-empty and not held.
- Reset mid-operation discards all queued entries. No write is issued in the cycle after reset.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - `query_data` = data of the youngest valid entry (including the draining output entry) whose destination matches `query_reg`.
  - The value is 0 when there is no match or `query_reg == 0`.
- Undefined:
  - `query_data` is tied to 32'd0.
  - No per-entry comparator data mux is built, and decode must stall on `query_pending`.

## Structure
- Shared package `mips_pkg`:
  - `REG_ADDR_W = 5`
  - `DATA_W = 32`
  - `REG_ZERO = 5'd0`
  - typedef `wb_entry_t` {5-bit reg, 32-bit data}
- One sub-module, `wb_match_unit`. It takes the entry array, valid mask, age order and `query_reg`, and returns `query_pending` and, under the macro, `query_data`.

## Test plan
- Reset, then push ($5, 0x1234) at edge 1 -> `RegWrite` = 1, `writeRegister` = 5 and `writeDataregs` = 0x1234 during cycle 2; `RegWrite` = 0 after, and `count` returns to 0.
- Push ($0, 0xFFFF_FFFF) -> `in_ready` = 1 and the handshake completes, but `count` stays 0, `RegWrite` never rises, and `query_pending` for `query_reg` = 0 is 0.
- Full and hold:
  - Hold `wb_hold` = 1 and push 5 entries ($1..$5) with `DEPTH` = 4 -> `in_ready` = 0 after the 4th, and the 5th is held off.
  - Release `wb_hold` -> writes drain in order $1, $2, $3, $4 on consecutive cycles, then $5.
- Bypass (macro on):
  - Push ($7, 0xA), ($7, 0xB) with `wb_hold` = 1 and `query_reg` = 7 -> `query_pending` = 1 and `query_data` = 0xB.
  - With the macro off -> `query_data` = 0.
- Simultaneous push/pop at `count` = 2 -> `count` stays 2 and order is preserved. Back-to-back single-entry pushes give continuous `RegWrite` = 1.
- Assert `rst` with 3 entries queued -> next cycle `RegWrite` = 0, `count` = 0, `in_ready` = 1, and no stale write appears.
